// File: rtl/ipsxe_floating_point_fl2fl_axis_buf_v1_0.sv
// ipsxe_floating_point_fl2fl_axis_buf_v1_0
// AXI4-Stream backpressure wrapper for the fixed-latency, valid-only fl2fl core.
// Upstream tready is granted only while a FIFO slot is guaranteed for every
// operand already sent into the core (credit = buffered + in-flight results).
// Optional feature macro: IPSXE_FL2FL_AXIS_STATUS_EN
//   defined   : per-entry {overflow, underflow} flags on o_m_tuser, sticky flags
//   undefined : o_m_tuser and sticky flags tied low, i_sticky_clr ignored
module ipsxe_floating_point_fl2fl_axis_buf_v1_0 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  i_aclk,
  input  logic                  i_areset_n,
  input  logic                  i_aclken,
  input  logic                  i_s_tvalid,
  output logic                  o_s_tready,
  output logic                  o_core_tvalid,
  input  logic [DATA_WIDTH-1:0] i_core_tdata,
  input  logic                  i_core_tvalid,
  input  logic                  i_core_overflow,
  input  logic                  i_core_underflow,
  output logic [DATA_WIDTH-1:0] o_m_tdata,
  output logic [1:0]            o_m_tuser,
  output logic                  o_m_tvalid,
  input  logic                  i_m_tready,
  input  logic                  i_sticky_clr,
  output logic                  o_ovf_sticky,
  output logic                  o_unf_sticky,
  output logic                  o_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic                  err_q, err_d;

  logic acc, wr, rd, full, wr_ok, drop;
  logic [SW-1:0] credit_used;

  // Credit check: a slot is reserved for each buffered and each in-flight result
  always_comb begin
    credit_used   = SW'(count_q) + SW'(inflight_q);
    o_s_tready    = credit_used < SW'(FIFO_DEPTH);
    o_core_tvalid = i_s_tvalid & o_s_tready;
    o_m_tvalid    = count_q != '0;
    o_m_tdata     = mem_q[rptr_q];
    o_err         = err_q;
  end

  // Event decode and next-state for counters, pointers and result storage
  always_comb begin
    acc        = i_aclken & i_s_tvalid & o_s_tready;
    wr         = i_aclken & i_core_tvalid;
    rd         = i_aclken & o_m_tvalid & i_m_tready;
    full       = count_q == CW'(FIFO_DEPTH);
    wr_ok      = wr & (~full | rd);
    drop       = wr & full & ~rd;

    count_d    = count_q;
    inflight_d = inflight_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    mem_d      = mem_q;
    err_d      = err_q;

    // Results the core emits without a matching credit never underflow the counter
    if (acc && !wr) begin
      inflight_d = inflight_q + CW'(1);
    end else if (!acc && wr && (inflight_q != '0)) begin
      inflight_d = inflight_q - CW'(1);
    end

    if (wr_ok && !rd) begin
      count_d = count_q + CW'(1);
    end else if (!wr_ok && rd) begin
      count_d = count_q - CW'(1);
    end

    if (wr_ok) begin
      mem_d[wptr_q] = i_core_tdata;
      wptr_d        = wptr_q + AW'(1);
    end

    if (rd) begin
      rptr_d = rptr_q + AW'(1);
    end

    if (drop) begin
      err_d = 1'b1;
    end
  end

  // State registers; clock enable is folded into the event decode above
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      count_q    <= '0;
      inflight_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      err_q      <= err_d;
      mem_q      <= mem_d;
    end
  end

`ifdef IPSXE_FL2FL_AXIS_STATUS_EN

  logic [1:0] flg_q [FIFO_DEPTH];
  logic [1:0] flg_d [FIFO_DEPTH];
  logic       ovf_sticky_q, ovf_sticky_d;
  logic       unf_sticky_q, unf_sticky_d;

  // Flag storage follows the data entry; sticky set wins over clear
  always_comb begin
    flg_d        = flg_q;
    ovf_sticky_d = ovf_sticky_q;
    unf_sticky_d = unf_sticky_q;

    if (wr_ok) begin
      flg_d[wptr_q] = {i_core_overflow, i_core_underflow};
    end

    if (i_aclken) begin
      if (i_sticky_clr) begin
        ovf_sticky_d = 1'b0;
        unf_sticky_d = 1'b0;
      end
      if (wr && i_core_overflow) begin
        ovf_sticky_d = 1'b1;
      end
      if (wr && i_core_underflow) begin
        unf_sticky_d = 1'b1;
      end
    end

    o_m_tuser    = flg_q[rptr_q];
    o_ovf_sticky = ovf_sticky_q;
    o_unf_sticky = unf_sticky_q;
  end

  // Flag and sticky registers
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      ovf_sticky_q <= 1'b0;
      unf_sticky_q <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        flg_q[i] <= '0;
      end
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
      unf_sticky_q <= unf_sticky_d;
      flg_q        <= flg_d;
    end
  end

`else

  logic unused_status;

  // Status feature absent: flags ignored, outputs tied low
  always_comb begin
    unused_status = i_sticky_clr ^ i_core_overflow ^ i_core_underflow;
    o_m_tuser     = 2'b00;
    o_ovf_sticky  = 1'b0;
    o_unf_sticky  = 1'b0;
  end

`endif

endmodule

// File: tb/tb_ipsxe_floating_point_fl2fl_axis_buf_v1_0.sv
// Scoreboard bench for ipsxe_floating_point_fl2fl_axis_buf_v1_0 with a
// behavioural fixed-latency core model in front of the buffer.
module tb_ipsxe_floating_point_fl2fl_axis_buf_v1_0;

  localparam int unsigned DW    = 32;
  localparam int unsigned LAT   = 1;
  localparam int unsigned DEPTH = 4;
`ifdef IPSXE_FL2FL_AXIS_STATUS_EN
  localparam bit STATUS = 1'b1;
`else
  localparam bit STATUS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          aclken;
  logic          s_tvalid;
  logic          s_tready;
  logic          core_in_v;
  logic [DW-1:0] s_data;
  logic [1:0]    s_flags;
  logic [DW-1:0] core_d;
  logic          core_v, core_ovf, core_unf;
  logic [DW-1:0] m_tdata;
  logic [1:0]    m_tuser;
  logic          m_tvalid;
  logic          m_tready;
  logic          sticky_clr;
  logic          ovf_sticky, unf_sticky, err;

  int total = 0;
  int bad   = 0;
  int acc_cnt = 0;
  int rd_cnt  = 0;
  int occ     = 0;
  logic [DW+1:0] exp_q[$];

  always #5 clk = ~clk;

  ipsxe_floating_point_fl2fl_axis_buf_v1_0 #(
    .DATA_WIDTH(DW), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_aclk(clk), .i_areset_n(rst_n), .i_aclken(aclken),
    .i_s_tvalid(s_tvalid), .o_s_tready(s_tready), .o_core_tvalid(core_in_v),
    .i_core_tdata(core_d), .i_core_tvalid(core_v),
    .i_core_overflow(core_ovf), .i_core_underflow(core_unf),
    .o_m_tdata(m_tdata), .o_m_tuser(m_tuser), .o_m_tvalid(m_tvalid),
    .i_m_tready(m_tready), .i_sticky_clr(sticky_clr),
    .o_ovf_sticky(ovf_sticky), .o_unf_sticky(unf_sticky), .o_err(err)
  );

  // Core model: identity result delayed LAT enabled cycles, reset with the buffer
  logic          cv [LAT];
  logic [DW-1:0] cd [LAT];
  logic [1:0]    cf [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(LAT); i++) begin
        cv[i] <= 1'b0; cd[i] <= '0; cf[i] <= '0;
      end
    end else if (aclken) begin
      cv[0] <= core_in_v; cd[0] <= s_data; cf[0] <= s_flags;
      for (int i = 1; i < int'(LAT); i++) begin
        cv[i] <= cv[i-1]; cd[i] <= cd[i-1]; cf[i] <= cf[i-1];
      end
    end
  end
  assign core_v   = cv[LAT-1];
  assign core_d   = cd[LAT-1];
  assign core_ovf = cf[LAT-1][1];
  assign core_unf = cf[LAT-1][0];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: inputs are stable from posedge+1 onward, so the negedge sees the
  // handshakes that the next posedge will commit
  logic          have_prev = 1'b0;
  logic          prev_en;
  logic [DW+4:0] prev_snap;
  always @(negedge clk) begin
    logic [DW+1:0] e;
    logic [DW+4:0] snap;
    snap = {m_tvalid, s_tready, err, m_tuser, m_tdata};
    if (!rst_n) begin
      exp_q.delete();
      occ = 0;
      have_prev = 1'b0;
    end else begin
      if (have_prev && !prev_en) chk("freeze", 64'(snap), 64'(prev_snap));
      chk("s_tready", 64'(s_tready), 64'(occ < int'(DEPTH)));
      chk("err", 64'(err), 64'(0));
      if (aclken && m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'(m_tdata), 64'(0));
          bad++; total++;
          $display("FAIL spurious_out: got output with empty scoreboard at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("m_tdata", 64'(m_tdata), 64'(e[DW-1:0]));
          chk("m_tuser", 64'(m_tuser), 64'(e[DW+1:DW]));
        end
        occ--;
        rd_cnt++;
      end
      if (aclken && s_tvalid && s_tready) begin
        exp_q.push_back({(STATUS ? s_flags : 2'b00), s_data});
        occ++;
        acc_cnt++;
      end
      prev_snap = snap;
      prev_en   = aclken;
      have_prev = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 300) begin
      step();
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL %s_timeout: still %0d pending, required 0", name, exp_q.size());
    end
  endtask

  initial begin
    int start;
    int n;
    rst_n = 1'b0; aclken = 1'b1; s_tvalid = 1'b0; s_data = '0; s_flags = '0;
    m_tready = 1'b0; sticky_clr = 1'b0;
    #2;
    chk("rst_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_tdata", 64'(m_tdata), 64'(0));
    chk("rst_tuser", 64'(m_tuser), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_ovf", 64'(ovf_sticky), 64'(0));
    chk("rst_tready", 64'(s_tready), 64'(1));
    step(); step();
    rst_n = 1'b1;
    step();

    // 1: back-to-back stream, latency 2
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_tvalid = 1'b1;
      s_data = 32'h3F80_0000 + 32'(i);
      s_flags = 2'b00;
      step();
      if (i == 0) chk("lat_cycle1", 64'(m_tvalid), 64'(0));
      if (i == 1) chk("lat_cycle2", 64'(m_tvalid), 64'(1));
    end
    s_tvalid = 1'b0;
    wait_empty("t1");

    // 2: consumer stalled, exactly DEPTH accepted
    m_tready = 1'b0;
    start = acc_cnt;
    for (int i = 0; i < 10; i++) begin
      s_tvalid = 1'b1;
      s_data = 32'h4000_0000 + 32'(i);
      step();
    end
    s_tvalid = 1'b0;
    step(); step();
    chk("t2_accepted", 64'(acc_cnt - start), 64'(DEPTH));
    chk("t2_tvalid", 64'(m_tvalid), 64'(1));
    chk("t2_tready_low", 64'(s_tready), 64'(0));
    m_tready = 1'b1;
    wait_empty("t2");
    chk("t2_tready_back", 64'(s_tready), 64'(1));

    // 3: random traffic and backpressure
    start = acc_cnt;
    n = 0;
    while (acc_cnt - start < 1000 && n < 20000) begin
      s_tvalid = ($urandom % 4) != 0;
      m_tready = $urandom % 2;
      s_data   = $urandom;
      s_flags  = 2'($urandom);
      step();
      n++;
    end
    total++;
    if (acc_cnt - start < 1000) begin
      bad++;
      $display("FAIL t3_timeout: accepted %0d required 1000", acc_cnt - start);
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    wait_empty("t3");

    // 4: clock enable dropped for 3 cycles mid-stream
    s_flags = 2'b00;
    for (int i = 0; i < 12; i++) begin
      s_tvalid = 1'b1;
      m_tready = (i % 3) != 0;
      s_data = 32'h5000_0000 + 32'(i);
      aclken = !(i >= 4 && i < 7);
      step();
    end
    aclken = 1'b1;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    wait_empty("t4");

    // 5: reset with 3 buffered and 1 in flight
    m_tready = 1'b0;
    start = acc_cnt;
    n = 0;
    while (acc_cnt - start < 4 && n < 50) begin
      s_tvalid = 1'b1;
      s_data = 32'h6000_0000 + 32'(n);
      step();
      n++;
    end
    s_tvalid = 1'b0;
    chk("t5_core_busy", 64'(core_v), 64'(1));
    chk("t5_buffered", 64'(m_tvalid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("t5_tvalid_rst", 64'(m_tvalid), 64'(0));
    chk("t5_tready_rst", 64'(s_tready), 64'(1));
    step(); step();
    rst_n = 1'b1;
    m_tready = 1'b1;
    step(); step(); step();
    chk("t5_tvalid_after", 64'(m_tvalid), 64'(0));
    chk("t5_tready_after", 64'(s_tready), 64'(1));

    // 6: overflow flag and sticky handling
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    chk("t6_ovf_cleared", 64'(ovf_sticky), 64'(0));
    s_tvalid = 1'b1;
    s_data = 32'h7F80_0000;
    s_flags = 2'b10;
    step();
    s_tvalid = 1'b0;
    s_flags = 2'b00;
    wait_empty("t6");
    chk("t6_ovf_sticky", 64'(ovf_sticky), 64'(STATUS));
    chk("t6_unf_sticky", 64'(unf_sticky), 64'(0));
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    chk("t6_ovf_clr", 64'(ovf_sticky), 64'(0));
    chk("end_err", 64'(err), 64'(0));
    chk("end_acc_rd", 64'(occ), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
